// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with rename-tag tracking.
// Per register it holds data, a busy bit and the ROB tag of the latest
// in-flight producer. There are NRD combinational read ports and NWB
// writeback (CDB) ports.
// Optional feature macro: RF_BYPASS_EN. When it is defined, a writeback that
// would clear busy is forwarded to reads in the same cycle.
module regfile_rename #(
    parameter int XLEN  = 32,
    parameter int NREG  = 64,
    parameter int TAG_W = 6,
    parameter int NRD   = 2,
    parameter int NWB   = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NRD*AW-1:0]       rd_addr,
    output logic [NRD*(XLEN+1)-1:0] rd_data,
    output logic [NRD*TAG_W-1:0]    rd_tag,
    input  logic                    dc_valid,
    input  logic [AW-1:0]           dc_rd,
    input  logic [TAG_W-1:0]        dc_tag,
    input  logic [NWB-1:0]          wb_valid,
    input  logic [NWB*AW-1:0]       wb_reg,
    input  logic [NWB*TAG_W-1:0]    wb_tag,
    input  logic [NWB*XLEN-1:0]     wb_data
);

    // Data storage is not reset. Register 0 is masked on the read side.
    logic [XLEN-1:0]  data_q [NREG];
    logic [NREG-1:0]  busy_vec;
    logic [TAG_W-1:0] tag_vec [NREG];

    // Writeback data write. Later ports override earlier ones, so the highest index wins.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NWB; i++) begin
            if (wb_valid[i] && (wb_reg[i*AW +: AW] != '0)) begin
                data_q[wb_reg[i*AW +: AW]] <= wb_data[i*XLEN +: XLEN];
            end
        end
    end

    // Per-register rename state: busy bit and producer tag.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic             busy_q, busy_d;
            logic [TAG_W-1:0] tag_q, tag_d;
            logic             clr;

            // Next state. A matching-tag writeback clears busy, and dispatch overrides it.
            always_comb begin
                clr = 1'b0;
                for (int i = 0; i < NWB; i++) begin
                    if (wb_valid[i] && (wb_reg[i*AW +: AW] == AW'(gi)) &&
                        (wb_reg[i*AW +: AW] != '0) &&
                        (wb_tag[i*TAG_W +: TAG_W] == tag_q)) begin
                        clr = 1'b1;
                    end
                end
                busy_d = busy_q & ~clr;
                tag_d  = tag_q;
                if (dc_valid && (dc_rd == AW'(gi)) && (dc_rd != '0)) begin
                    busy_d = 1'b1;
                    tag_d  = dc_tag;
                end
            end

            // State register. Reset and flush both drop all rename state and any dispatch.
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    busy_q <= 1'b0;
                    tag_q  <= '0;
                end else begin
                    busy_q <= busy_d;
                    tag_q  <= tag_d;
                end
            end

            assign busy_vec[gi] = busy_q;
            assign tag_vec[gi]  = tag_q;
        end
    endgenerate

    // Combinational read ports.
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]    addr;
            logic [XLEN:0]    word;
            logic [TAG_W-1:0] tag;

            // Stored-state read with optional same-cycle forwarding; register 0 reads as zero.
            always_comb begin
                addr = rd_addr[gi*AW +: AW];
                word = {busy_vec[addr], data_q[addr]};
                tag  = tag_vec[addr];
`ifdef RF_BYPASS_EN
                for (int i = 0; i < NWB; i++) begin
                    if (wb_valid[i] && (wb_reg[i*AW +: AW] == addr) && busy_vec[addr] &&
                        (wb_tag[i*TAG_W +: TAG_W] == tag_vec[addr])) begin
                        word = {1'b0, wb_data[i*XLEN +: XLEN]};
                    end
                end
`endif
                if (addr == '0) begin
                    word = '0;
                    tag  = '0;
                end
            end

            assign rd_data[gi*(XLEN+1) +: (XLEN+1)] = word;
            assign rd_tag[gi*TAG_W +: TAG_W]        = tag;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_rename.sv
// Directed testbench for regfile_rename with a queue of expected read results.
module tb_regfile_rename;
    localparam int XLEN  = 32;
    localparam int NREG  = 64;
    localparam int TAG_W = 6;
    localparam int NRD   = 2;
    localparam int NWB   = 2;
    localparam int AW    = 6;

    logic                    clk = 1'b0;
    logic                    reset, flush;
    logic [NRD*AW-1:0]       rd_addr;
    logic [NRD*(XLEN+1)-1:0] rd_data;
    logic [NRD*TAG_W-1:0]    rd_tag;
    logic                    dc_valid;
    logic [AW-1:0]           dc_rd;
    logic [TAG_W-1:0]        dc_tag;
    logic [NWB-1:0]          wb_valid;
    logic [NWB*AW-1:0]       wb_reg;
    logic [NWB*TAG_W-1:0]    wb_tag;
    logic [NWB*XLEN-1:0]     wb_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int              port;
        logic            busy;
        logic [XLEN-1:0] data;
        bit              chk_data;
        logic [TAG_W-1:0] tag;
        bit              chk_tag;
        string           name;
    } exp_t;

    exp_t sb[$];

    regfile_rename #(
        .XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD), .NWB(NWB)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_tag(rd_tag),
        .dc_valid(dc_valid), .dc_rd(dc_rd), .dc_tag(dc_tag),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_tag(wb_tag), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush    = 1'b0;
        dc_valid = 1'b0;
        dc_rd    = '0;
        dc_tag   = '0;
        wb_valid = '0;
        wb_reg   = '0;
        wb_tag   = '0;
        wb_data  = '0;
    endtask

    task automatic dispatch(input int r, input int t);
        dc_valid = 1'b1;
        dc_rd    = AW'(r);
        dc_tag   = TAG_W'(t);
    endtask

    task automatic wb(input int p, input int r, input int t, input logic [XLEN-1:0] d);
        wb_valid[p]              = 1'b1;
        wb_reg[p*AW +: AW]       = AW'(r);
        wb_tag[p*TAG_W +: TAG_W] = TAG_W'(t);
        wb_data[p*XLEN +: XLEN]  = d;
    endtask

    // Drive a read address and push the expected outcome.
    task automatic expect_rd(input int p, input int r, input logic b,
                             input logic [XLEN-1:0] d, input bit cd,
                             input int t, input bit ct, input string name);
        exp_t e;
        rd_addr[p*AW +: AW] = AW'(r);
        e.port = p; e.busy = b; e.data = d; e.chk_data = cd;
        e.tag = TAG_W'(t); e.chk_tag = ct; e.name = name;
        sb.push_back(e);
    endtask

    // Pop every pending expectation and compare it with the combinational read result.
    task automatic check_reads();
        exp_t e;
        logic [XLEN:0]    word;
        logic [TAG_W-1:0] tg;
        #1;
        while (sb.size() > 0) begin
            e    = sb.pop_front();
            word = rd_data[e.port*(XLEN+1) +: (XLEN+1)];
            tg   = rd_tag[e.port*TAG_W +: TAG_W];
            checks++;
            assert (word[XLEN] === e.busy) else begin
                errors++;
                $error("FAIL %s busy: got %0b expected %0b", e.name, word[XLEN], e.busy);
            end
            if (e.chk_data) begin
                checks++;
                assert (word[XLEN-1:0] === e.data) else begin
                    errors++;
                    $error("FAIL %s data: got %h expected %h", e.name, word[XLEN-1:0], e.data);
                end
            end
            if (e.chk_tag) begin
                checks++;
                assert (tg === e.tag) else begin
                    errors++;
                    $error("FAIL %s tag: got %0d expected %0d", e.name, tg, e.tag);
                end
            end
            $display("check %s port%0d: busy=%0b data=%h tag=%0d", e.name, e.port,
                     word[XLEN], word[XLEN-1:0], tg);
        end
    endtask

    initial begin
        reset   = 1'b1;
        rd_addr = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        expect_rd(0, 5, 1'b0, '0, 1'b0, 0, 1'b1, "reset_r5");
        expect_rd(1, 0, 1'b0, '0, 1'b1, 0, 1'b1, "reset_r0");
        check_reads();

        // Dispatch, then matching writeback
        dispatch(3, 9);
        tick();
        idle();
        expect_rd(0, 3, 1'b1, '0, 1'b0, 9, 1'b1, "disp_r3");
        check_reads();
        wb(0, 3, 9, 32'hDEADBEEF);
        tick();
        idle();
        expect_rd(0, 3, 1'b0, 32'hDEADBEEF, 1'b1, 0, 1'b0, "wb_r3");
        check_reads();

        // Stale-tag writeback
        dispatch(3, 9);
        tick();
        dispatch(3, 12);
        tick();
        idle();
        wb(0, 3, 9, 32'h1);
        tick();
        idle();
        expect_rd(0, 3, 1'b1, 32'h1, 1'b1, 12, 1'b1, "stale_r3");
        check_reads();
        wb(1, 3, 12, 32'h2);
        tick();
        idle();
        expect_rd(1, 3, 1'b0, 32'h2, 1'b1, 0, 1'b0, "fresh_r3");
        check_reads();

        // Same-cycle dispatch and writeback to one register
        dispatch(7, 2);
        tick();
        idle();
        dispatch(7, 4);
        wb(0, 7, 2, 32'h77);
        tick();
        idle();
        expect_rd(0, 7, 1'b1, 32'h77, 1'b1, 4, 1'b1, "disp_wins_r7");
        check_reads();

        // Register 0 ignores dispatch and writeback
        dispatch(0, 3);
        wb(1, 0, 3, 32'hFF);
        tick();
        idle();
        expect_rd(1, 0, 1'b0, '0, 1'b1, 0, 1'b1, "r0_ignored");
        check_reads();

        // Flush with busy registers and a concurrent dispatch
        dispatch(1, 1);
        tick();
        dispatch(2, 2);
        tick();
        idle();
        expect_rd(0, 1, 1'b1, '0, 1'b0, 1, 1'b1, "pre_flush_r1");
        expect_rd(1, 2, 1'b1, '0, 1'b0, 2, 1'b1, "pre_flush_r2");
        check_reads();
        flush = 1'b1;
        dispatch(4, 5);
        tick();
        idle();
        expect_rd(0, 1, 1'b0, '0, 1'b0, 0, 1'b1, "flush_r1");
        expect_rd(1, 2, 1'b0, '0, 1'b0, 0, 1'b1, "flush_r2");
        check_reads();
        expect_rd(0, 4, 1'b0, '0, 1'b0, 0, 1'b1, "flush_r4");
        check_reads();

        // Same-cycle writeback visibility, with and without forwarding
        dispatch(6, 3);
        tick();
        idle();
        wb(1, 6, 3, 32'h55);
`ifdef RF_BYPASS_EN
        expect_rd(0, 6, 1'b0, 32'h55, 1'b1, 0, 1'b0, "bypass_same_r6");
`else
        expect_rd(0, 6, 1'b1, '0, 1'b0, 3, 1'b1, "nobypass_same_r6");
`endif
        check_reads();
        tick();
        idle();
        expect_rd(0, 6, 1'b0, 32'h55, 1'b1, 0, 1'b0, "after_wb_r6");
        check_reads();

        // Two writeback ports to one register: the highest port wins data and busy clears on any match
        dispatch(9, 7);
        tick();
        idle();
        wb(0, 9, 7, 32'hAAAA_0000);
        wb(1, 9, 8, 32'hBBBB_1111);
        tick();
        idle();
        expect_rd(1, 9, 1'b0, 32'hBBBB_1111, 1'b1, 0, 1'b0, "multi_wb_r9");
        check_reads();

        // Top register and maximum tag
        dispatch(63, 63);
        tick();
        idle();
        expect_rd(0, 63, 1'b1, '0, 1'b0, 63, 1'b1, "disp_r63");
        check_reads();
        wb(0, 63, 63, 32'h1234_5678);
        tick();
        idle();
        expect_rd(1, 63, 1'b0, 32'h1234_5678, 1'b1, 0, 1'b0, "wb_r63");
        check_reads();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_rename.md
# regfile_rename

Parametrised architectural register file with rename-tag tracking for the out-of-order core. It keeps per-register data, a busy bit and the ROB tag of the latest in-flight producer. It generalises the single-dispatch, single-writeback register file to NRD read ports and NWB writeback (CDB) ports, with optional same-cycle writeback bypass. It sits between decode/dispatch (rename lookup and allocation) and the ROB/CDB (result writeback); mispredict flush clears all rename state.

## Interface
- XLEN, 32, data width
- NREG, 64, number of architectural registers (power of two, ≥2); AW = $clog2(NREG)
- TAG_W, 6, ROB tag width
- NRD, 2, number of read ports
- NWB, 2, number of writeback ports

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  mispredict flush, synchronous
- rd_addr  in  NRD*AW  read register index, port i at [i*AW +: AW]
- rd_data  out  NRD*(XLEN+1)  per port {busy, data}
- rd_tag  out  NRD*TAG_W  per port producer tag
- dc_valid  in  1  dispatch allocates a destination this cycle
- dc_rd  in  AW  dispatch destination register
- dc_tag  in  TAG_W  ROB entry allocated to dc_rd
- wb_valid  in  NWB  writeback strobe per port
- wb_reg  in  NWB*AW  writeback destination register
- wb_tag  in  NWB*TAG_W  producer tag of the writeback
- wb_data  in  NWB*XLEN  result data

## Operation
- State: data[NREG] (not reset), busy[NREG], tag[NREG].
- Register 0: reads return {0, 0} and tag 0. Dispatch to 0 and writeback to 0 are ignored. busy[0] is always 0.
- Reset or flush: all busy ← 0, all tag ← 0. Any dispatch in that cycle is dropped. Writeback data is still written to data[]; busy-clear is moot.
- Dispatch (dc_valid, dc_rd≠0, no reset/flush): busy[dc_rd] ← 1, tag[dc_rd] ← dc_tag.
- Writeback port i (wb_valid[i], wb_reg≠0): data[wb_reg] ← wb_data, unconditionally.
  - busy[wb_reg] ← 0 only if busy[wb_reg]=1 and wb_tag == tag[wb_reg]. The comparison uses the pre-edge tag.
  - A stale-tag writeback updates data but leaves busy and tag unchanged.
- Dispatch and writeback to the same register in the same cycle: dispatch wins for busy and tag (busy=1, tag=dc_tag). The data write still occurs.
- Multiple writeback ports to the same register in the same cycle: the highest port index wins for data. The busy clear is an OR across matching ports.
- Reads are combinational from current state. The read tag is meaningful only when busy=1.

## Timing
- Read latency 0 (combinational). Dispatch and writeback effects are visible on reads the cycle after the edge.
- Exception: with RF_BYPASS_EN, a matching writeback is visible on reads in the same cycle.
- After reset: every rd_data busy bit = 0, every rd_tag = 0. Data is undefined except register 0, which reads 0.
- Flush takes effect at the edge. The cycle after flush, all reads show busy=0.
- No handshake/backpressure. The producer guarantees at most one live tag per ROB entry.

## Configuration
- RF_BYPASS_EN defined: for each read port, if any wb port i has wb_valid[i], wb_reg==rd_addr≠0, busy[rd_addr]=1 and wb_tag==tag[rd_addr], then rd_data returns {0, wb_data[i]} in that cycle. Highest matching index wins.
- RF_BYPASS_EN undefined: no forwarding. Reads return stored state (busy=1) and the consumer must capture the result from the CDB.

## Test plan
- Reset, then read r5 and r0 → both busy=0, tag=0; r0 data=0.
- Dispatch r3 with tag 9; next cycle read r3 → busy=1, tag=9. Then wb r3 tag 9 with data 0xDEADBEEF; next cycle → {0, 0xDEADBEEF}.
- Stale writeback: r3 dispatched tag 9, then re-dispatched tag 12; wb r3 tag 9 data 0x1 → data=0x1, busy stays 1, tag=12. A later wb with tag 12 clears busy.
- Same-cycle dispatch r7 tag 4 plus wb r7 tag 2 (matching old tag 2) → next cycle busy=1, tag=4. Dispatch to r0 → r0 stays {0, 0}.
- Flush with r1, r2 busy and concurrent dispatch r4 tag 5 → next cycle r1, r2, r4 busy=0, tag=0.
- RF_BYPASS_EN: r6 busy tag 3; wb port 1 r6 tag 3 data 0x55 with read of r6 in the same cycle → rd_data={0, 0x55} that cycle. Without the macro the same stimulus gives busy=1 that cycle and {0, 0x55} next cycle.
